coprocessador_ula_matriz: RTL

//  Matrix arithmetic engine sitting directly downstream of gerencia_matriz.

---
 rtl/coprocessador_ula_matriz.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/coprocessador_ula_matriz.sv
// coprocessador_ula_matriz
//   Matrix arithmetic engine fed by gerencia_matriz. It latches two packed
//   operand matrices and runs one multi-cycle operation over the active
//   tamanho x tamanho window. The packed result is written to
//   matriz_resultante only when the operation completes.
//
//   Ports
//     clk, reset         single clock; synchronous active-high reset
//     start              request pulse, sampled only in IDLE
//     operacao[2:0]      000 A+B, 001 A-B, 010 A*B, 011 B(0,0)*A,
//                        100 transpose(A), 101 -A, 11x illegal
//     tamanho[4:0]       active dimension, legal range 2..N
//     matriz1, matriz2   operands; element (i,j) at [(i*N+j)*ELEM_W +: ELEM_W]
//     matriz_resultante  registered result, same packing
//     busy               high from accept until the cycle done rises
//     done               one-cycle completion pulse
//     erro, overflow     status flags, valid when done is high
//
//   Handshake: an operation is accepted on a clock edge where the FSM is in
//   IDLE and start=1. In any other state start is ignored and not queued.
//   done pulses for exactly one cycle per accepted operation. A reset while
//   an operation is running aborts it without issuing done.
module coprocessador_ula_matriz #(
  parameter  int N      = 5,
  parameter  int ELEM_W = 9,
  localparam int MAT_W  = N*N*ELEM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operacao,
  input  logic [4:0]       tamanho,
  input  logic [MAT_W-1:0] matriz1,
  input  logic [MAT_W-1:0] matriz2,
  output logic [MAT_W-1:0] matriz_resultante,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output logic             overflow
);

  localparam int ACC_W = 2*ELEM_W + 3;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PRD_W = 2*ELEM_W;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

  // FSM state, kept as a named signal so checkers can bind to it
  state_t                   state;
  logic [2:0]               op_q;
  logic [4:0]               tam_q;
  logic [MAT_W-1:0]         a_q;
  logic [MAT_W-1:0]         b_q;
  logic [MAT_W-1:0]         acc;
  logic [IDX_W-1:0]         i_q;
  logic [IDX_W-1:0]         j_q;
  logic [IDX_W-1:0]         k_q;
  logic signed [ACC_W-1:0]  mac_q;
  logic                     err_q;

  function automatic logic signed [ELEM_W-1:0] elem(
    input logic [MAT_W-1:0] m,
    input logic [IDX_W-1:0] r,
    input logic [IDX_W-1:0] c
  );
    int base;
    base = (int'(r) * N + int'(c)) * ELEM_W;
    return m[base +: ELEM_W];
  endfunction

  logic signed [ELEM_W-1:0] a_ij, b_ij, a_ji, a_ik, b_kj, s_el;
  logic signed [PRD_W-1:0]  p_scale, p_mac;
  logic signed [ACC_W-1:0]  ew_full, mac_sum, el_full;
  logic [ELEM_W-1:0]        el_trunc;
  logic                     el_ovf, last_k, last_pos, pos_in, k_in;
  logic                     start_illegal;
  int                       pos_base;

  always_comb begin
    a_ij = elem(a_q, i_q, j_q);
    b_ij = elem(b_q, i_q, j_q);
    a_ji = elem(a_q, j_q, i_q);
    a_ik = elem(a_q, i_q, k_q);
    b_kj = elem(b_q, k_q, j_q);
    s_el = elem(b_q, '0, '0);

    pos_in = (5'(i_q) < tam_q) && (5'(j_q) < tam_q);
    k_in   = (5'(k_q) < tam_q);

    // Products at double width; MAC terms outside the window add nothing
    p_scale = PRD_W'(a_ij) * PRD_W'(s_el);
    p_mac   = k_in ? (PRD_W'(a_ik) * PRD_W'(b_kj)) : '0;
    mac_sum = mac_q + ACC_W'(p_mac);

    case (op_q)
      3'b000:  ew_full = ACC_W'(a_ij) + ACC_W'(b_ij);
      3'b001:  ew_full = ACC_W'(a_ij) - ACC_W'(b_ij);
      3'b011:  ew_full = ACC_W'(p_scale);
      3'b100:  ew_full = ACC_W'(a_ji);
      3'b101:  ew_full = -ACC_W'(a_ij);
      default: ew_full = '0;
    endcase

    el_full = (op_q == 3'b010) ? mac_sum : ew_full;
    if (!pos_in) el_full = '0;

    // Wrap to element width; a mismatch after sign extension is an overflow
    el_trunc = el_full[ELEM_W-1:0];
    el_ovf   = (ACC_W'($signed(el_trunc)) != el_full);

    last_k   = (op_q != 3'b010) || (k_q == IDX_W'(N-1));
    last_pos = (i_q == IDX_W'(N-1)) && (j_q == IDX_W'(N-1));
    pos_base = (int'(i_q) * N + int'(j_q)) * ELEM_W;

    start_illegal = (operacao[2:1] == 2'b11) || (tamanho < 5'd2) ||
                    (tamanho > 5'(N));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      op_q              <= '0;
      tam_q             <= '0;
      a_q               <= '0;
      b_q               <= '0;
      acc               <= '0;
      i_q               <= '0;
      j_q               <= '0;
      k_q               <= '0;
      mac_q             <= '0;
      err_q             <= 1'b0;
      matriz_resultante <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      erro              <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= matriz1;
            b_q      <= matriz2;
            op_q     <= operacao;
            tam_q    <= tamanho;
            overflow <= 1'b0;
            erro     <= 1'b0;
            busy     <= 1'b1;
            err_q    <= start_illegal;
            // Illegal requests skip the walk and leave the result untouched
            state    <= start_illegal ? DONE : LOAD;
          end
        end
        LOAD: begin
          acc   <= '0;
          i_q   <= '0;
          j_q   <= '0;
          k_q   <= '0;
          mac_q <= '0;
          state <= EXEC;
        end
        EXEC: begin
          if (last_k) begin
            acc[pos_base +: ELEM_W] <= el_trunc;
            if (el_ovf) overflow <= 1'b1;
            mac_q <= '0;
            k_q   <= '0;
            if (last_pos) begin
              i_q   <= '0;
              j_q   <= '0;
              state <= DONE;
            end else if (j_q == IDX_W'(N-1)) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            mac_q <= mac_sum;
            k_q   <= k_q + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          erro  <= err_q;
          if (!err_q) matriz_resultante <= acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
